mat_vec_mult_seq: RTL and testbench

Parametrised, sequential successor to the fixed combinational matrix-vector multiplier. Holds an N x N coefficient matrix in internal registers, written one element at a time. For each accepted input vector it computes y = M·v with a single shared multiply-accumulate unit and streams the N result words out in row order under a valid/ready handshake. It sits between the ui_in/uio_in capture logic and the uo_out/uio_out drivers of the top-level wrapper.

---
 rtl/mat_vec_mult_seq_if.sv | 35 +++
 rtl/mat_vec_mult_seq.sv | 123 ++++++++++++
 tb/tb_mat_vec_mult_seq.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mat_vec_mult_seq_if.sv
// Handshake and write-bus bundle for mat_vec_mult_seq: matrix write port,
// vector input channel and result output channel.
interface mat_vec_mult_seq_if #(
  parameter int N     = 2,
  parameter int W     = 4,
  parameter int OUT_W = 2*W + $clog2(N)
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic            wr_en;
  logic [IW-1:0]   wr_row;
  logic [IW-1:0]   wr_col;
  logic [W-1:0]    wr_data;
  logic            wr_err;

  logic            in_valid;
  logic            in_ready;
  logic [N*W-1:0]  in_vec;

  logic            out_valid;
  logic            out_ready;
  logic [OUT_W-1:0] out_data;
  logic [IW-1:0]   out_row;
  logic            done;

  modport master (
    output wr_en, wr_row, wr_col, wr_data, in_valid, in_vec, out_ready,
    input  wr_err, in_ready, out_valid, out_data, out_row, done
  );

  modport slave (
    input  wr_en, wr_row, wr_col, wr_data, in_valid, in_vec, out_ready,
    output wr_err, in_ready, out_valid, out_data, out_row, done
  );
endinterface

// File: rtl/mat_vec_mult_seq.sv
// Sequential N x N matrix-vector multiplier using one shared MAC unit.
// Define MVM_SIGNED_EN for two's complement elements; default is unsigned.
module mat_vec_mult_seq #(
  parameter int N     = 2,
  parameter int W     = 4,
  parameter int OUT_W = 2*W + $clog2(N)
) (
  input logic             clk,
  input logic             rst_n,
  mat_vec_mult_seq_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  generate
    if (N < 2) begin : g_bad_n
      $error("mat_vec_mult_seq: N must be at least 2");
    end
    if (OUT_W < 2*W + $clog2(N)) begin : g_bad_out_w
      $error("mat_vec_mult_seq: OUT_W too narrow for the accumulated sum");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t           state, state_next;
  logic [W-1:0]     mat [N][N];
  logic [W-1:0]     vec [N];
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] term;
  logic [2*W-1:0]   prod;
  logic [IW-1:0]    row, col;
  logic             wr_err_q, done_q;
  logic             vec_accept, out_accept;
  logic             last_col, last_row, wr_ok;

  assign last_col = (col == IW'(N-1));
  assign last_row = (row == IW'(N-1));
  assign wr_ok    = bus.wr_en && (state == IDLE) &&
                    (int'(bus.wr_row) < N) && (int'(bus.wr_col) < N);

  // Product is formed at full 2W width, then widened to the accumulator width.
  always_comb begin
`ifdef MVM_SIGNED_EN
    prod = {{W{mat[row][col][W-1]}}, mat[row][col]} *
           {{W{vec[col][W-1]}}, vec[col]};
    term = {{(OUT_W-2*W){prod[2*W-1]}}, prod};
`else
    prod = {{W{1'b0}}, mat[row][col]} * {{W{1'b0}}, vec[col]};
    term = {{(OUT_W-2*W){1'b0}}, prod};
`endif
  end

  always_comb begin
    state_next = state;
    vec_accept = 1'b0;
    out_accept = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          vec_accept = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        if (last_col) state_next = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          out_accept = 1'b1;
          state_next = last_row ? IDLE : MAC;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A write in the same cycle as vector acceptance lands before the first MAC read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          mat[r][c] <= '0;
      for (int j = 0; j < N; j++)
        vec[j] <= '0;
      acc      <= '0;
      row      <= '0;
      col      <= '0;
      wr_err_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_err_q <= bus.wr_en && !wr_ok;
      done_q   <= out_accept && last_row;
      if (wr_ok)
        mat[bus.wr_row][bus.wr_col] <= bus.wr_data;
      if (vec_accept) begin
        for (int j = 0; j < N; j++)
          vec[j] <= bus.in_vec[j*W +: W];
        acc <= '0;
        row <= '0;
        col <= '0;
      end else if (state == MAC) begin
        acc <= acc + term;
        col <= last_col ? '0 : col + 1'b1;
      end else if (out_accept) begin
        acc <= '0;
        col <= '0;
        if (!last_row) row <= row + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = acc;
  assign bus.out_row   = row;
  assign bus.done      = done_q;
  assign bus.wr_err    = wr_err_q;
endmodule

// File: tb/tb_mat_vec_mult_seq.sv
// Directed, table-driven testbench for mat_vec_mult_seq (N=2, W=4).
module tb_mat_vec_mult_seq;
  localparam int N     = 2;
  localparam int W     = 4;
  localparam int OUT_W = 9;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mat_vec_mult_seq_if #(.N(N), .W(W), .OUT_W(OUT_W)) bus ();

  mat_vec_mult_seq #(.N(N), .W(W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string            name;
    logic [W-1:0]     m00, m01, m10, m11;
    logic [W-1:0]     v0, v1;
    logic [OUT_W-1:0] y0, y1;
  } vec_t;

  vec_t table_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic writeElem(input int r, input int c, input logic [W-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_row  = r[0:0];
    bus.wr_col  = c[0:0];
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic loadMatrix(input logic [W-1:0] m00, m01, m10, m11);
    writeElem(0, 0, m00);
    writeElem(0, 1, m01);
    writeElem(1, 0, m10);
    writeElem(1, 1, m11);
  endtask

  // Exact-cycle walk through one vector with out_ready held high.
  task automatic runVector(input logic [W-1:0] v0, v1,
                           input logic [OUT_W-1:0] y0, y1, input string tag);
    bus.in_vec    = {v1, v0};
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    checkOutput({tag, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    checkOutput({tag, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
    tick();
    checkOutput({tag, ".early_valid"}, 32'(bus.out_valid), 32'd0);
    tick();
    checkOutput({tag, ".valid0"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, ".data0"},  32'(bus.out_data),  32'(y0));
    checkOutput({tag, ".row0"},   32'(bus.out_row),   32'd0);
    tick();
    checkOutput({tag, ".gap_valid"}, 32'(bus.out_valid), 32'd0);
    tick();
    tick();
    checkOutput({tag, ".valid1"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, ".data1"},  32'(bus.out_data),  32'(y1));
    checkOutput({tag, ".row1"},   32'(bus.out_row),   32'd1);
    tick();
    checkOutput({tag, ".done"},     32'(bus.done),     32'd1);
    checkOutput({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    checkOutput({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  task automatic applyStimulus(input vec_t t);
    loadMatrix(t.m00, t.m01, t.m10, t.m11);
    runVector(t.v0, t.v1, t.y0, t.y1, t.name);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_row    = '0;
    bus.wr_col    = '0;
    bus.wr_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;

`ifdef MVM_SIGNED_EN
    table_q.push_back('{"signed_basic", 4'hF, 4'h2, 4'h3, 4'hC, 4'h5, 4'hA, 9'h1EF, 9'd39});
    table_q.push_back('{"signed_extreme", 4'h8, 4'h8, 4'h7, 4'h7, 4'h8, 4'h8, 9'd128, 9'h190});
`else
    table_q.push_back('{"basic", 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 9'd17, 9'd39});
    table_q.push_back('{"all_max", 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 9'd450, 9'd450});
    table_q.push_back('{"identity", 4'd1, 4'd0, 4'd0, 4'd1, 4'd7, 4'd9, 9'd7, 9'd9});
    table_q.push_back('{"cross", 4'd0, 4'd15, 4'd8, 4'd0, 4'd3, 4'd2, 9'd30, 9'd24});
`endif

    #3;
    checkOutput("reset.in_ready",  32'(bus.in_ready),  32'd1);
    checkOutput("reset.out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset.out_data",  32'(bus.out_data),  32'd0);
    checkOutput("reset.out_row",   32'(bus.out_row),   32'd0);
    checkOutput("reset.done",      32'(bus.done),      32'd0);
    checkOutput("reset.wr_err",    32'(bus.wr_err),    32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < table_q.size(); i++)
      applyStimulus(table_q[i]);

    // Backpressure on row 0: result must hold until accepted.
    loadMatrix(4'd1, 4'd2, 4'd3, 4'd4);
    checkOutput("idle_write.wr_err", 32'(bus.wr_err), 32'd0);
    bus.in_vec    = {4'd6, 4'd5};
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp.valid_held", 32'(bus.out_valid), 32'd1);
      checkOutput("bp.data_held",  32'(bus.out_data),  32'd17);
      checkOutput("bp.row_held",   32'(bus.out_row),   32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    checkOutput("bp.still_valid", 32'(bus.out_valid), 32'd1);
    tick();
    checkOutput("bp.row1_not_ready", 32'(bus.out_valid), 32'd0);
    tick();
    tick();
    checkOutput("bp.valid1", 32'(bus.out_valid), 32'd1);
    checkOutput("bp.data1",  32'(bus.out_data),  32'd39);
    checkOutput("bp.row1",   32'(bus.out_row),   32'd1);
    tick();
    checkOutput("bp.done", 32'(bus.done), 32'd1);
    tick();

    // Write during MAC is rejected; a later IDLE write applies to the next vector.
    bus.in_vec    = {4'd6, 4'd5};
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.wr_en     = 1'b1;
    bus.wr_row    = 1'b0;
    bus.wr_col    = 1'b0;
    bus.wr_data   = 4'd9;
    tick();
    bus.wr_en = 1'b0;
    checkOutput("busy_write.wr_err", 32'(bus.wr_err), 32'd1);
    tick();
    checkOutput("busy_write.wr_err_pulse", 32'(bus.wr_err), 32'd0);
    checkOutput("busy_write.data0", 32'(bus.out_data), 32'd17);
    tick();
    tick();
    tick();
    checkOutput("busy_write.data1", 32'(bus.out_data), 32'd39);
    tick();
    tick();
    writeElem(0, 0, 4'd7);
    checkOutput("late_write.wr_err", 32'(bus.wr_err), 32'd0);
    runVector(4'd5, 4'd6, 9'd47, 9'd39, "late_write");

    // Reset during the row-1 MAC abandons the vector and clears the matrix.
    bus.in_vec    = {4'd6, 4'd5};
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst.in_ready",  32'(bus.in_ready),  32'd1);
    checkOutput("midrst.out_data",  32'(bus.out_data),  32'd0);
    checkOutput("midrst.out_row",   32'(bus.out_row),   32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    runVector(4'd5, 4'd6, 9'd0, 9'd0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
